// File: rtl/fp_pkg.sv
// Shared constants, FSM states and input classes for the float-field to integer converter.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int INT_W  = 32;
    localparam int BIAS   = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_NAN       = 3'd0,
        CLS_INF       = 3'd1,
        CLS_UNDER     = 3'd2,
        CLS_OVER      = 3'd3,
        CLS_EXACT_MIN = 3'd4,
        CLS_NORMAL    = 3'd5
    } cls_t;

endpackage

// File: rtl/fp_classify.sv
// Maps sign/exponent/mantissa fields to a conversion class and the unbiased exponent.
// Latency: purely combinational.
// Backpressure: none; the caller samples the outputs only when it accepts the fields.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int INT_W  = fp_pkg::INT_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input  logic                      signbit,
    input  logic [EXP_W-1:0]          exponent,
    input  logic [MANT_W-1:0]         mantissa,
    output cls_t                      cls,
    output logic signed [EXP_W+1:0]   e
);

    localparam logic signed [EXP_W+1:0] E_TOP = (EXP_W+2)'(INT_W - 1);

    assign e = $signed({2'b00, exponent}) - $signed((EXP_W+2)'(BIAS));

    always_comb begin
        cls = CLS_NORMAL;
        if (exponent == EXP_W'(EXP_MAX)) begin
            cls = (mantissa != '0) ? CLS_NAN : CLS_INF;
        end else if (e < $signed((EXP_W+2)'(0))) begin
            cls = CLS_UNDER;
        end else if (e >= E_TOP) begin
            // -2^31 is the one value at e==31 that still fits
            if (signbit && (e == E_TOP) && (mantissa == '0))
                cls = CLS_EXACT_MIN;
            else
                cls = CLS_OVER;
        end
    end

endmodule

// File: rtl/fp_field_to_int.sv
// Converts split single-precision fields to a truncated 32-bit integer with invalid/inexact flags.
// Latency: 1 cycle for special cases, 2+|e-23| cycles on the normal path (one shift per cycle).
// Backpressure: one conversion in flight; in_ready only in IDLE, result held until out_ready.
module fp_field_to_int
    import fp_pkg::*;
#(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int INT_W  = fp_pkg::INT_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              signbit,
    input  logic [EXP_W-1:0]  exponent,
    input  logic [MANT_W-1:0] mantissa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INT_W-1:0]  out_int,
    output logic              out_invalid,
    output logic              out_inexact
);

    localparam int CNT_W = $clog2(MANT_W + 1);
    localparam logic signed [EXP_W+1:0] E_MANT = (EXP_W+2)'(MANT_W);

    state_t                  state;
    cls_t                    cls;
    logic signed [EXP_W+1:0] e;
    logic [CNT_W-1:0]        e_lo;
    logic                    left_c;
    logic [CNT_W-1:0]        cnt_c;
    logic [INT_W-1:0]        mag;
    logic [CNT_W-1:0]        count;
    logic                    shift_left;
    logic                    sign_r;

    fp_classify #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .INT_W  (INT_W),
        .BIAS   (BIAS)
    ) u_classify (
        .signbit  (signbit),
        .exponent (exponent),
        .mantissa (mantissa),
        .cls      (cls),
        .e        (e)
    );

    // Only meaningful for the normal class, where 0 <= e <= INT_W-2
    assign e_lo   = e[CNT_W-1:0];
    assign left_c = (e > E_MANT);
    assign cnt_c  = left_c ? (e_lo - CNT_W'(MANT_W)) : (CNT_W'(MANT_W) - e_lo);

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_int     <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
            mag         <= '0;
            count       <= '0;
            shift_left  <= 1'b0;
            sign_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r      <= signbit;
                        out_int     <= '0;
                        out_invalid <= 1'b0;
                        out_inexact <= 1'b0;
                        case (cls)
                            CLS_NAN: begin
                                out_invalid <= 1'b1;
                                out_valid   <= 1'b1;
                                state       <= DONE;
                            end
                            CLS_INF, CLS_OVER: begin
                                out_int     <= signbit ? INT_W'(INT_MIN) : INT_W'(INT_MAX);
                                out_invalid <= 1'b1;
                                out_valid   <= 1'b1;
                                state       <= DONE;
                            end
                            CLS_EXACT_MIN: begin
                                out_int   <= INT_W'(INT_MIN);
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            CLS_UNDER: begin
                                out_inexact <= (exponent != '0) || (mantissa != '0);
                                out_valid   <= 1'b1;
                                state       <= DONE;
                            end
                            default: begin
                                mag        <= {{(INT_W-MANT_W-1){1'b0}}, 1'b1, mantissa};
                                count      <= cnt_c;
                                shift_left <= left_c;
                                state      <= (cnt_c != '0) ? SHIFT : NEGATE;
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    if (shift_left) begin
                        mag <= mag << 1;
                    end else begin
                        mag         <= mag >> 1;
                        out_inexact <= out_inexact | mag[0];
                    end
                    count <= count - 1'b1;
                    if (count == CNT_W'(1))
                        state <= NEGATE;
                end
                NEGATE: begin
                    out_int   <= sign_r ? (~mag + 1'b1) : mag;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_field_to_int.sv
// Directed-vector bench for fp_field_to_int: values, flags, latency, backpressure and reset.
module tb_fp_field_to_int;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        signbit;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_int;
    logic        out_invalid;
    logic        out_inexact;

    int checks   = 0;
    int failures = 0;

    fp_field_to_int dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signbit     (signbit),
        .exponent    (exponent),
        .mantissa    (mantissa),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_int     (out_int),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one conversion, measures latency, optionally holds out_ready low, then drains.
    task automatic convert(input string tag, input logic s, input logic [7:0] ex, input logic [22:0] m,
                           input logic [31:0] exp_int, input logic exp_inv, input logic exp_inx,
                           input int exp_lat, input int hold);
        int lat;
        check({tag, " ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        signbit  = s;
        exponent = ex;
        mantissa = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        signbit  = 1'b0;
        exponent = 8'd0;
        mantissa = 23'd0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " int"}, out_int, exp_int);
        check({tag, " invalid"}, {31'b0, out_invalid}, {31'b0, exp_inv});
        check({tag, " inexact"}, {31'b0, out_inexact}, {31'b0, exp_inx});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            signbit  = 1'b1;
            exponent = 8'd140;
            mantissa = 23'h123456;
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, " hold int"}, out_int, exp_int);
            check({tag, " hold flags"}, {30'b0, out_invalid, out_inexact}, {30'b0, exp_inv, exp_inx});
            check({tag, " hold ready"}, {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " drained"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        signbit   = 1'b0;
        exponent  = 8'd0;
        mantissa  = 23'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset valid", {31'b0, out_valid}, 32'd0);
        check("reset int", out_int, 32'd0);
        check("reset flags", {30'b0, out_invalid, out_inexact}, 32'd0);
        check("reset ready", {31'b0, in_ready}, 32'd1);

        //       tag          s     exp     mant          int            inv   inx   lat hold
        convert("10.0",      1'b0, 8'd130, 23'h200000, 32'd10,        1'b0, 1'b0, 22, 0);
        convert("-2.75",     1'b1, 8'd128, 23'h300000, 32'hFFFFFFFE,  1'b0, 1'b1, 24, 0);
        convert("+2^31",     1'b0, 8'd158, 23'h000000, 32'h7FFFFFFF,  1'b1, 1'b0, 1,  0);
        convert("-2^31",     1'b1, 8'd158, 23'h000000, 32'h80000000,  1'b0, 1'b0, 1,  0);
        convert("-2^31+ulp", 1'b1, 8'd158, 23'h000001, 32'h80000000,  1'b1, 1'b0, 1,  0);
        convert("nan",       1'b0, 8'd255, 23'h400000, 32'd0,         1'b1, 1'b0, 1,  0);
        convert("0.5",       1'b0, 8'd126, 23'h000000, 32'd0,         1'b0, 1'b1, 1,  0);
        convert("+0",        1'b0, 8'd0,   23'h000000, 32'd0,         1'b0, 1'b0, 1,  0);
        convert("denorm",    1'b1, 8'd0,   23'h000001, 32'd0,         1'b0, 1'b1, 1,  0);
        convert("-inf",      1'b1, 8'd255, 23'h000000, 32'h80000000,  1'b1, 1'b0, 1,  0);
        convert("max",       1'b0, 8'd157, 23'h7FFFFF, 32'h7FFFFF80,  1'b0, 1'b0, 9,  0);
        convert("1.0",       1'b0, 8'd127, 23'h000000, 32'd1,         1'b0, 1'b0, 25, 0);
        convert("-1.0",      1'b1, 8'd127, 23'h000000, 32'hFFFFFFFF,  1'b0, 1'b0, 25, 0);
        convert("2^23",      1'b0, 8'd150, 23'h000000, 32'h00800000,  1'b0, 1'b0, 2,  0);
        convert("-1.5 bp",   1'b1, 8'd127, 23'h400000, 32'hFFFFFFFF,  1'b0, 1'b1, 25, 5);

        // Reset in the middle of a long right shift
        check("pre-abort ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        signbit  = 1'b0;
        exponent = 8'd127;
        mantissa = 23'h0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("shifting ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort valid", {31'b0, out_valid}, 32'd0);
        check("abort ready", {31'b0, in_ready}, 32'd1);
        check("abort int", out_int, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("abort stays idle", {30'b0, out_valid, in_ready}, 32'b01);
        convert("after abort", 1'b0, 8'd130, 23'h200000, 32'd10, 1'b0, 1'b0, 22, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_field_to_int.md
Name: fp_field_to_int

Overview:
- Multi-cycle converter that consumes a single-precision result in split-field form (sign, 8-bit biased exponent, 23-bit mantissa), the same field format the floating-point adder produces.
- Returns a 32-bit two's-complement integer, truncated toward zero, plus invalid and inexact flags.
- Sits downstream of the adder as the reader of its output fields.
- Uses a one-bit-per-cycle shifter instead of a barrel shifter, to keep area small.

Parameters:
- EXP_W, 8, exponent field width
- MANT_W, 23, mantissa field width (hidden bit excluded)
- INT_W, 32, integer result width
- BIAS, 127, exponent bias
- Only the default values are verified; other values are not supported.

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input fields are valid
- in_ready  output  1  converter can accept; combinational, equals (state==IDLE)
- signbit  input  1  sign field
- exponent  input  EXP_W  biased exponent field
- mantissa  input  MANT_W  fraction field
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- out_int  output  INT_W  signed integer result
- out_invalid  output  1  NaN, infinity or out-of-range input
- out_inexact  output  1  nonzero fraction bits were discarded

Behaviour:
- Reset: state=IDLE; out_valid=0; out_int=0; out_invalid=0; out_inexact=0. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: the next state is IDLE and any in-flight conversion is discarded.
- Accept: a transfer occurs on an edge where in_valid && in_ready. Fields are registered on that edge. Let e = exponent - BIAS.
- Classification on accept:
  - exponent==255, mantissa!=0 (NaN): result 0, invalid=1, go to DONE.
  - exponent==255, mantissa==0 (infinity): saturate, invalid=1, go to DONE.
  - e<0 (includes zero and denormals): result 0, inexact=(exponent!=0 || mantissa!=0), go to DONE.
  - e>=31: saturate, invalid=1, go to DONE. Exception: signbit=1, e==31, mantissa==0 gives 0x80000000 with invalid=0.
  - Saturation value: 0x7FFFFFFF when signbit=0, 0x80000000 when signbit=1.
  - Otherwise (0<=e<=30): mag={8'b0,1'b1,mantissa}, count=|e-23|, dir=left if e>23 else right. Go to SHIFT if count!=0, else NEGATE.
- SHIFT: each cycle shift mag by one bit in dir and decrement count. On a right shift, OR the bit shifted out into the inexact sticky. Go to NEGATE when the count reaches 0 (the cycle that performs the last shift).
- NEGATE: out_int = signbit ? -mag : mag, evaluated mod 2^32. Go to DONE.
- DONE: out_valid=1. out_int and flags stay stable until out_ready is sampled high; on that edge out_valid=0 and the next state is IDLE.
- Latency from the accept edge T:
  - Special cases: out_valid from T+1.
  - Normal path: out_valid from T+2+count.
  - Worst case is count=23 (e=0), out_valid at T+25.
- Throughput: one conversion in flight. in_ready=0 in SHIFT, NEGATE and DONE. There is no same-cycle DONE-to-accept overlap.
- in_valid while not ready is ignored; fields are sampled only at accept.

Decomposition:
- Shared package fp_pkg holds:
  - constants EXP_W, MANT_W, BIAS, EXP_MAX=255, INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000
  - state encoding IDLE, SHIFT, NEGATE, DONE
- One natural sub-module: fp_classify, a combinational block that maps the fields to one of {nan, inf, underflow, overflow, exact_min, normal} and outputs e. The FSM and shifter stay in the top module.

Test Plan:
- 10.0 (sign 0, exp 130, mant 0x200000) -> out_int=10, invalid=0, inexact=0; out_valid exactly 22 cycles after accept (count=20).
- -2.75 (sign 1, exp 128, mant 0x300000) -> out_int=0xFFFFFFFE (-2), inexact=1, invalid=0; out_valid at T+24.
- 2^31 (sign 0, exp 158, mant 0) -> 0x7FFFFFFF, invalid=1, at T+1. Sign 1, same fields -> 0x80000000, invalid=0, at T+1.
- NaN (exp 255, mant 0x400000) -> 0, invalid=1. Then 0.5 (exp 126, mant 0) -> 0, inexact=1. Then +0 -> 0 with no flags.
- Max in-range input (sign 0, exp 157, mant 0x7FFFFF) -> 0x7FFFFF80, inexact=0; out_valid at T+9.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> out_valid, out_int and flags stay constant and in_ready=0. Separately, assert reset during SHIFT -> next cycle IDLE, out_valid=0, in_ready=1, and the following conversion is correct.
